// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the push-button conditioning front end:
// channel state encoding, counter width helper and default board timing.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_ARMING  = 2'd1,
    DB_PRESSED = 2'd2,
    DB_DISARM  = 2'd3
  } db_state_t;

  localparam int unsigned DEF_N_BTN           = 5;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms at 100 MHz
  localparam int unsigned DEF_REPEAT_EN       = 1;
  localparam int unsigned DEF_REPEAT_DELAY    = 50000000;  // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;  // 100 ms

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM with stability
// counter, registered level/press/release outputs and hold-to-repeat pulses.
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_rpt
);

  localparam int unsigned DCNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RCNT_W = cnt_width(REPEAT_DELAY);
  localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST   = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic              RPT_ON      = (REPEAT_EN != 0);

  logic              r_s1, r_s2;
  db_state_t         r_state, w_state_nxt;
  logic [DCNT_W-1:0] r_dcnt, w_dcnt_nxt;
  logic [RCNT_W-1:0] r_rcnt, w_rcnt_nxt;
  logic              r_level, w_level_nxt;
  logic              r_press, w_press_nxt;
  logic              r_release, w_release_nxt;
  logic              r_rpt, w_rpt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_state   <= DB_IDLE;
      r_dcnt    <= '0;
      r_rcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_rpt     <= 1'b0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_state   <= w_state_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_rpt     <= w_rpt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_dcnt_nxt    = r_dcnt;
    w_rcnt_nxt    = r_rcnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_rpt_nxt     = 1'b0;

    unique case (r_state)
      DB_IDLE: begin
        if (r_s2) begin
          w_state_nxt = DB_ARMING;
          w_dcnt_nxt  = '0;
        end
      end
      DB_ARMING: begin
        if (!r_s2) begin
          w_state_nxt = DB_IDLE;
        end else if (r_dcnt == DCNT_LAST) begin
          w_state_nxt = DB_PRESSED;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
          w_rcnt_nxt  = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      DB_PRESSED: begin
        if (!r_s2) begin
          w_state_nxt = DB_DISARM;
          w_dcnt_nxt  = '0;
        end
      end
      DB_DISARM: begin
        if (r_s2) begin
          w_state_nxt = DB_PRESSED;
        end else if (r_dcnt == DCNT_LAST) begin
          w_state_nxt   = DB_IDLE;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      default: w_state_nxt = DB_IDLE;
    endcase

    // Repeat timer keeps running through release bounces; an accepted release wins.
    if ((r_state == DB_PRESSED || r_state == DB_DISARM) && !w_release_nxt) begin
      if (r_rcnt == RCNT_LAST) begin
        w_rcnt_nxt = RCNT_RELOAD;
        w_rpt_nxt  = RPT_ON;
      end else begin
        w_rcnt_nxt = r_rcnt + 1'b1;
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_rpt     = r_rpt;

endmodule

// File: rtl/btn_debounce.sv
// Push-button front end: N_BTN fully independent debounce channels
// in the board clock domain.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N_BTN           = DEF_N_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] rpt_pulse
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_raw     (btn_raw[g]),
      .o_level   (btn_level[g]),
      .o_press   (press_pulse[g]),
      .o_release (release_pulse[g]),
      .o_rpt     (rpt_pulse[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with short timing (debounce 4, repeat 10/3);
// a second instance with repeat disabled shares the same stimulus.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_raw = '0;
  logic [4:0] lvl, prs, rel, rpt;
  logic [4:0] lvl_n, prs_n, rel_n, rpt_n;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  btn_debounce #(
    .N_BTN(5), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl), .press_pulse(prs), .release_pulse(rel), .rpt_pulse(rpt)
  );

  btn_debounce #(
    .N_BTN(5), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut_norpt (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(lvl_n), .press_pulse(prs_n), .release_pulse(rel_n), .rpt_pulse(rpt_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] e;

    // Reset then idle
    rst = 1'b1;
    btn_raw = '0;
    repeat (3) tick();
    chk("reset_level", lvl, 5'b0);
    chk("reset_pulses", prs | rel | rpt, 5'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_outputs", lvl | prs | rel | rpt, 5'b0);
    end

    // Clean press on channel 0: pulse registered 6 edges after first sample
    btn_raw[0] = 1'b1;
    for (int t = 0; t <= 8; t++) begin
      tick();
      e = (t == 6) ? 5'b00001 : 5'b00000;
      chk("press0_pulse", prs, e);
      e = (t >= 6) ? 5'b00001 : 5'b00000;
      chk("press0_level", lvl, e);
    end

    // Glitch on channel 1: high for 3 samples only
    btn_raw[1] = 1'b1;
    repeat (3) tick();
    btn_raw[1] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk("glitch1_press", prs, 5'b0);
      chk("glitch1_level", lvl, 5'b00001);
    end

    // Release bounce on channel 0: low for 2 samples
    btn_raw[0] = 1'b0;
    repeat (2) tick();
    btn_raw[0] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      chk("bounce0_release", rel, 5'b0);
      chk("bounce0_level", lvl, 5'b00001);
    end

    // Final release of channel 0
    btn_raw[0] = 1'b0;
    for (int t = 0; t <= 9; t++) begin
      tick();
      e = (t == 6) ? 5'b00001 : 5'b00000;
      chk("release0_pulse", rel, e);
      e = (t < 6) ? 5'b00001 : 5'b00000;
      chk("release0_level", lvl, e);
    end

    // Auto-repeat on channel 2
    btn_raw[2] = 1'b1;
    for (int t = 0; t <= 6; t++) begin
      tick();
      e = (t == 6) ? 5'b00100 : 5'b00000;
      chk("press2_pulse", prs, e);
    end
    for (int j = 1; j <= 30; j++) begin
      tick();
      e = (j >= 10 && (j - 10) % 3 == 0) ? 5'b00100 : 5'b00000;
      chk("rpt2_pulse", rpt, e);
      chk("rpt2_disabled", rpt_n, 5'b0);
      chk("rpt2_level", lvl, 5'b00100);
      chk("rpt2_nopress", prs, 5'b0);
    end
    btn_raw[2] = 1'b0;
    repeat (10) tick();
    chk("rel2_level", lvl, 5'b0);

    // Reset mid-debounce with channels 3 and 4 pressed together
    btn_raw[3] = 1'b1;
    btn_raw[4] = 1'b1;
    repeat (5) tick();
    chk("pre_rst_press", prs, 5'b0);
    rst = 1'b1;
    for (int t = 0; t < 2; t++) begin
      tick();
      chk("in_rst_outputs", lvl | prs | rel | rpt, 5'b0);
    end
    rst = 1'b0;
    for (int t = 0; t <= 8; t++) begin
      tick();
      e = (t == 6) ? 5'b11000 : 5'b00000;
      chk("requal34_pulse", prs, e);
      e = (t >= 6) ? 5'b11000 : 5'b00000;
      chk("requal34_level", lvl, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
